// File: rtl/counterupdown_param_1clk_negedge_async_resetn.sv
// rtl/counterupdown_param_1clk_negedge_async_resetn.sv - prescaled up/down counter, falling-edge clocked
// Wrap or saturate at the bounds, with a terminal-count pulse and a sticky wrapped flag.
module counterupdown_param_1clk_negedge_async_resetn #(
  parameter int               WIDTH       = 16,
  parameter int               PRE_W       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clear_wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q   = RESET_VALUE;
  logic [PRE_W-1:0] pre_cnt   = '0;
  logic             tc_q      = 1'b0;
  logic             wrapped_q = 1'b0;

  logic             tick;
  logic             at_bound;
  logic             bound_hit;
  logic [WIDTH-1:0] next_count;

  assign tick      = enable && (pre_cnt == prescale);
  assign at_bound  = up_down ? (count_q == MAX) : (count_q == '0);
  assign bound_hit = tick && at_bound;

  always_comb begin
    next_count = count_q;
    if (at_bound) begin
      if (!SATURATE) next_count = up_down ? '0 : MAX;
    end else if (up_down) begin
      next_count = count_q + ONE;
    end else begin
      next_count = count_q - ONE;
    end
  end

  always_ff @(negedge clock0 or negedge reset) begin
    if (!reset) begin
      count_q   <= RESET_VALUE;
      pre_cnt   <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      // a bound hit wins over a simultaneous clear so no event is lost
      if (bound_hit)       wrapped_q <= 1'b1;
      else if (clear_wrap) wrapped_q <= 1'b0;

      if (load) begin
        count_q <= load_value;
        pre_cnt <= '0;
        tc_q    <= 1'b0;
      end else if (tick) begin
        count_q <= next_count;
        pre_cnt <= '0;
        tc_q    <= bound_hit;
      end else begin
        tc_q <= 1'b0;
        // pre_cnt may sit above a newly lowered prescale; it wraps around
        if (enable) pre_cnt <= pre_cnt + PRE_ONE;
      end
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_counterupdown_param_1clk_negedge_async_resetn.sv
// tb/tb_counterupdown_param_1clk_negedge_async_resetn.sv - directed vector bench for the prescaled up/down counter
// Two 4-bit instances share all inputs: one wrapping, one saturating.
module tb_counterupdown_param_1clk_negedge_async_resetn;

  typedef struct {
    logic       en;
    logic       ud;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] ps;
    logic       cw;
    logic [3:0] ec;
    logic       et;
    logic       ew;
    logic       chk_w;
  } vec_t;

  logic       clock0 = 1'b1;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] prescale;
  logic       clear_wrap;
  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, wrapped_w, wrapped_s;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vq[$];

  always #5 clock0 = ~clock0;

  counterupdown_param_1clk_negedge_async_resetn #(
    .WIDTH(4), .PRE_W(4), .RESET_VALUE(4'hF), .SATURATE(1'b0)
  ) dut_w (
    .clock0(clock0), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .prescale(prescale),
    .clear_wrap(clear_wrap), .count(count_w), .tc(tc_w), .wrapped(wrapped_w)
  );

  counterupdown_param_1clk_negedge_async_resetn #(
    .WIDTH(4), .PRE_W(4), .RESET_VALUE(4'hF), .SATURATE(1'b1)
  ) dut_s (
    .clock0(clock0), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .prescale(prescale),
    .clear_wrap(clear_wrap), .count(count_s), .tc(tc_s), .wrapped(wrapped_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic ud, input logic ld,
                              input logic [3:0] lv, input logic [3:0] ps, input logic cw,
                              input logic [3:0] ec, input logic et, input logic ew,
                              input logic chk_w);
    vec_t v;
    v.en = en; v.ud = ud; v.ld = ld; v.lv = lv; v.ps = ps; v.cw = cw;
    v.ec = ec; v.et = et; v.ew = ew; v.chk_w = chk_w;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic en, input logic ud, input logic ld,
                       input logic [3:0] lv, input logic [3:0] ps, input logic cw);
    enable = en; up_down = ud; load = ld; load_value = lv; prescale = ps; clear_wrap = cw;
  endtask

  // inputs change 1 time unit after the falling edge; outputs are read there too
  task automatic step();
    @(negedge clock0);
    #1;
  endtask

  initial begin
    // count down from 15 through the 0 -> 15 wrap
    for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 0, 0, 4'(14 - i), 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 15, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 14, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 14, 0, 0, 1);
    // load 13 then count up every third edge
    add(1, 1, 1, 13, 2, 0, 13, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 13, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 13, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 14, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 14, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 14, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 15, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 15, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 15, 0, 0, 1);
    add(1, 1, 0, 0, 2, 0, 0, 1, 1, 1);
    add(1, 1, 0, 0, 2, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 2, 1, 0, 0, 0, 1);
    // load beats a bound-hit tick; wrapped not judged on that edge
    add(0, 1, 1, 15, 0, 0, 15, 0, 0, 1);
    add(1, 1, 1, 5, 0, 0, 5, 0, 0, 0);
    add(0, 1, 1, 15, 0, 1, 15, 0, 0, 1);
    // clear_wrap together with a bound hit leaves wrapped set
    add(1, 1, 0, 0, 0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    // prescale lowered below pre_cnt: pre_cnt runs 3..15,0,1 before ticking
    add(0, 1, 1, 0, 5, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 5, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 5, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 5, 0, 0, 0, 1, 1);
    for (int i = 0; i < 14; i++) add(1, 1'(i % 2), 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 0, 1, 1);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset count_w", count_w, 15);
    chk("reset tc_w", tc_w, 0);
    chk("reset wrapped_w", wrapped_w, 0);
    chk("reset count_s", count_s, 15);
    @(negedge clock0);
    #2 reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].ud, vq[i].ld, vq[i].lv, vq[i].ps, vq[i].cw);
      step();
      chk($sformatf("vec%0d count", i), count_w, vq[i].ec);
      chk($sformatf("vec%0d tc", i), tc_w, vq[i].et);
      if (vq[i].chk_w) chk($sformatf("vec%0d wrapped", i), wrapped_w, vq[i].ew);
    end

    // saturating instance holds at 15 and pulses tc on each repeated hit
    drive(0, 1, 1, 14, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0);
    step(); chk("sat up1 count", count_s, 15); chk("sat up1 tc", tc_s, 0);
    step(); chk("sat up2 count", count_s, 15); chk("sat up2 tc", tc_s, 1);
    step(); chk("sat up3 count", count_s, 15); chk("sat up3 tc", tc_s, 1);
    chk("sat up wrapped", wrapped_s, 1);
    drive(0, 1, 0, 0, 0, 0);
    step(); chk("sat frozen count", count_s, 15); chk("sat frozen tc", tc_s, 0);

    // saturating hold at 0 versus wrap to 15
    drive(0, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    chk("sat down count", count_s, 0); chk("sat down tc", tc_s, 1);
    chk("wrap down count", count_w, 15); chk("wrap down tc", tc_w, 1);

    // enable=0 freezes pre_cnt mid-period
    drive(0, 0, 1, 3, 2, 0); step();
    drive(1, 0, 0, 0, 2, 0); step();
    drive(0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("freeze%0d count_s", i), count_s, 3);
    end
    drive(1, 0, 0, 0, 2, 0);
    step(); chk("unfreeze1 count_s", count_s, 3);
    step(); chk("unfreeze2 count_s", count_s, 2); chk("unfreeze2 count_w", count_w, 2);

    // async reset mid-period (count=7, pre_cnt=1), then a load during reset
    drive(0, 1, 1, 7, 3, 0); step();
    drive(1, 1, 0, 0, 3, 0); step();
    chk("pre-reset count_w", count_w, 7);
    chk("pre-reset wrapped_w", wrapped_w, 1);
    #2 reset = 1'b0;
    #1;
    chk("async count_w", count_w, 15);
    chk("async tc_w", tc_w, 0);
    chk("async wrapped_w", wrapped_w, 0);
    chk("async count_s", count_s, 15);
    drive(1, 0, 1, 3, 0, 0);
    step();
    chk("held reset count_w", count_w, 15);
    #2 reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    step(); chk("resume1 count_w", count_w, 14); chk("resume1 tc_w", tc_w, 0);
    step(); chk("resume2 count_w", count_w, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
